// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scan sequencer for a 4x4 active-high matrix keypad. It drives the columns
// one-hot in rotation on a divided scan tick and samples the rows. A key is
// accepted as pressed or released only after it has been stable for a number
// of ticks. Each accepted press becomes one event on a valid/ack handshake.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   row_in    in   [3:0] row sense, bit r high when a key in row r of the
//                  driven column is down
//   col_out   out  [3:0] one-hot column drive
//   key_valid out  an event is pending
//   key_code  out  [3:0] pending key, row*4+col
//   key_ack   in   consumer takes the pending event
//   key_down  out  high while a debounced key is held
//   overrun   out  one-cycle pulse when a pending event is overwritten
//
// Build option: define KEYPAD_REPEAT_EN to emit an auto-repeat event every
// REPEAT_TICKS ticks while a key stays held. Without it, each press gives
// exactly one event and no repeat counter exists.
module keypad_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 10000,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_e;

  // Lowest set row wins when several keys share the driven column.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    if (rows[0]) begin
      lowest_row = 2'd0;
    end else if (rows[1]) begin
      lowest_row = 2'd1;
    end else if (rows[2]) begin
      lowest_row = 2'd2;
    end else begin
      lowest_row = 2'd3;
    end
  endfunction

  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    col_onehot = 4'b0001 << idx;
  endfunction

  if (CLK_DIV < 2 || DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1) begin : g_param_check
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  logic [CW-1:0] div_q;
  state_e        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    cap_row_q, cap_row_d;
  logic [1:0]    cap_col_q, cap_col_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    col_out_q;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_down_q;
  logic          overrun_q, overrun_d;
  logic          tick_s;
  logic          held_s;
  logic          event_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = (REPEAT_TICKS > 2) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  assign tick_s = (div_q == DIV_MAX);
  // The column stays on cap_col outside SCAN, so this is the captured key.
  assign held_s = row_in[cap_row_q];

  // Scan / debounce state machine, advanced only on tick cycles.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    event_s   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    if (tick_s) begin
      case (state_q)
        ST_SCAN: begin
          if (row_in == 4'b0000) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cap_row_d = lowest_row(row_in);
            cap_col_d = col_idx_q;
            deb_cnt_d = {DW{1'b0}};
            state_d   = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (held_s) begin
            if (deb_cnt_q == DEB_MAX) begin
              state_d   = ST_PRESSED;
              event_s   = 1'b1;
              rel_cnt_d = {DW{1'b0}};
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d = {RW{1'b0}};
`endif
            end else begin
              deb_cnt_d = deb_cnt_q + DW'(1);
            end
          end else begin
            // Bounce: give up on this key and move on to the next column.
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (held_s) begin
            rel_cnt_d = {DW{1'b0}};
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt_q == REP_MAX) begin
              rep_cnt_d = {RW{1'b0}};
              event_s   = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + RW'(1);
            end
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = {RW{1'b0}};
`endif
            if (rel_cnt_q == DEB_MAX) begin
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              rel_cnt_d = rel_cnt_q + DW'(1);
            end
          end
        end
        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Event handshake: a new event always wins over an ack in the same cycle.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = 1'b0;
    if (event_s) begin
      key_valid_d = 1'b1;
      key_code_d  = {cap_row_q, cap_col_q};
      overrun_d   = key_valid_q & ~key_ack;
    end else if (key_ack) begin
      key_valid_d = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= {CW{1'b0}};
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      cap_row_q   <= 2'd0;
      cap_col_q   <= 2'd0;
      deb_cnt_q   <= {DW{1'b0}};
      rel_cnt_q   <= {DW{1'b0}};
      col_out_q   <= 4'b0001;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= {RW{1'b0}};
`endif
    end else begin
      div_q       <= tick_s ? {CW{1'b0}} : div_q + CW'(1);
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cap_row_q   <= cap_row_d;
      cap_col_q   <= cap_col_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      col_out_q   <= col_onehot(col_idx_d);
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= (state_d == ST_PRESSED);
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign col_out   = col_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a virtual 4x4 keypad (16-bit "keys held" mask)
// produces row_in from the DUT's column drive. A cycle-level reference model
// built from the behavioural rules is compared every clock, alongside a
// table of idle-scan vectors and directed corner-case sequences.
module tb_keypad_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int REP     = 5;

  localparam int PH_IDLE    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_HELD    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        key_down;
  logic        overrun;
  logic [15:0] keys;

  always #5 clk = ~clk;

  // Keypad matrix: key r*4+c closes row r onto column c.
  always_comb begin
    row_in = 4'b0000;
    for (int r = 0; r < 4; r++) row_in[r] = |(keys[r*4 +: 4] & col_out);
  end

  keypad_scan_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .REPEAT_TICKS  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ack  (key_ack),
    .key_down (key_down),
    .overrun  (overrun)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_div, m_col, m_phase, m_key, m_seen, m_gone, m_since, m_code;
  logic m_valid, m_down, m_over;

  // Stimulus controls
  logic        rst_v = 1'b1;
  logic        ack_v = 1'b0;
  logic [15:0] keys_v = 16'h0000;
  logic        auto_ack = 1'b0;
  int          n_edges, val_rises, ovr_cycles;
  logic        prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [15:0] k, input logic a);
    bit ev;
    int rows;
    int low;
    if (r) begin
      m_div = 0; m_col = 0; m_phase = PH_IDLE; m_key = 0;
      m_seen = 0; m_gone = 0; m_since = 0;
      m_valid = 1'b0; m_code = 0; m_down = 1'b0; m_over = 1'b0;
    end else begin
      ev = 1'b0;
      if (m_div == CLK_DIV - 1) begin
        rows = 0;
        for (int i = 0; i < 4; i++) if (k[i*4 + m_col]) rows |= (1 << i);
        if (m_phase == PH_IDLE) begin
          if (rows == 0) m_col = (m_col + 1) % 4;
          else begin
            low = 0;
            while (((rows >> low) & 1) == 0) low++;
            m_key = low * 4 + m_col;
            m_seen = 1;
            m_phase = PH_CONFIRM;
          end
        end else if (m_phase == PH_CONFIRM) begin
          if (k[m_key]) begin
            m_seen++;
            if (m_seen == DEB + 1) begin
              m_phase = PH_HELD; ev = 1'b1; m_gone = 0; m_since = 0;
            end
          end else begin
            m_phase = PH_IDLE;
            m_col = (m_col + 1) % 4;
          end
        end else begin
          if (k[m_key]) begin
            m_gone = 0;
            m_since++;
`ifdef KEYPAD_REPEAT_EN
            if (m_since == REP) begin ev = 1'b1; m_since = 0; end
`endif
          end else begin
            m_since = 0;
            m_gone++;
            if (m_gone == DEB) begin
              m_phase = PH_IDLE;
              m_col = (m_col + 1) % 4;
            end
          end
        end
      end
      m_over = 1'b0;
      if (ev) begin
        m_over = m_valid && !a;
        m_valid = 1'b1;
        m_code = m_key;
      end else if (a) begin
        m_valid = 1'b0;
      end
      m_down = (m_phase == PH_HELD);
      m_div = (m_div + 1) % CLK_DIV;
    end
  endtask

  // Apply inputs at a negedge, let one posedge pass, compare at the next negedge.
  task automatic step(input int n);
    logic [10:0] exp_v;
    for (int i = 0; i < n; i++) begin
      if (auto_ack) ack_v = key_valid;
      rst = rst_v; key_ack = ack_v; keys = keys_v;
      model_step(rst_v, keys_v, ack_v);
      @(negedge clk);
      n_edges++;
      if (key_valid === 1'b1 && prev_valid !== 1'b1) val_rises++;
      prev_valid = key_valid;
      if (overrun === 1'b1) ovr_cycles++;
      exp_v = {4'(4'b0001 << m_col), m_valid, 4'(m_code), m_down, m_over};
      check("model", {21'd0, col_out, key_valid, key_code, key_down, overrun}, {21'd0, exp_v});
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1; ack_v = 1'b0; keys_v = 16'h0000; auto_ack = 1'b0;
    step(2);
    rst_v = 1'b0;
    n_edges = 0; val_rises = 0; ovr_cycles = 0;
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int i = 0; i < max && key_valid !== 1'b1; i++) step(1);
    check(name, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_release(input string name, input int max);
    for (int i = 0; i < max && key_down !== 1'b0; i++) step(1);
    check(name, {31'd0, key_down}, 32'd0);
  endtask

  typedef struct {
    int          edges;
    logic [15:0] keys;
    logic [3:0]  col;
    logic        valid;
    logic        down;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int sel, hold;
    // Idle scan: column k%4 is driven during edges 4k..4k+3 after reset.
    tbl[0] = '{1,  16'h0000, 4'b0001, 1'b0, 1'b0};
    tbl[1] = '{3,  16'h0000, 4'b0001, 1'b0, 1'b0};
    tbl[2] = '{4,  16'h0000, 4'b0010, 1'b0, 1'b0};
    tbl[3] = '{8,  16'h0000, 4'b0100, 1'b0, 1'b0};
    tbl[4] = '{11, 16'h0000, 4'b0100, 1'b0, 1'b0};
    tbl[5] = '{12, 16'h0000, 4'b1000, 1'b0, 1'b0};
    tbl[6] = '{16, 16'h0000, 4'b0001, 1'b0, 1'b0};
    tbl[7] = '{20, 16'h0000, 4'b0010, 1'b0, 1'b0};
    tbl[8] = '{40, 16'h0000, 4'b0100, 1'b0, 1'b0};

    // 1. Reset and idle scan
    do_reset();
    check("reset_col", {28'd0, col_out}, 32'h1);
    check("reset_valid", {31'd0, key_valid}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      keys_v = tbl[i].keys;
      step(tbl[i].edges - n_edges);
      check("idle_col", {28'd0, col_out}, {28'd0, tbl[i].col});
      check("idle_valid", {31'd0, key_valid}, {31'd0, tbl[i].valid});
      check("idle_down", {31'd0, key_down}, {31'd0, tbl[i].down});
    end

    // 2. Clean press of key 9 (row 2, col 1)
    do_reset();
    keys_v = 16'h0200;
    wait_valid("press_valid", 100);
    // col1 reached at tick 1, captured at tick 2, accepted DEB ticks later
    check("press_latency", n_edges, (2 + DEB) * CLK_DIV);
    check("press_code", {28'd0, key_code}, 32'h9);
    check("press_down", {31'd0, key_down}, 32'd1);
    step(2);
    ack_v = 1'b1;
    step(1);
    ack_v = 1'b0;
    check("ack_clears", {31'd0, key_valid}, 32'd0);
    keys_v = 16'h0000;
    wait_release("release", 100);
    // released after edge 23; three zero ticks at edges 24, 28, 32
    check("release_edge", n_edges, 32);
    check("resume_col", {28'd0, col_out}, 32'h4);
    check("one_event", val_rises, 1);

    // 3. Bounce rejection: key 0 seen for a single tick
    do_reset();
    keys_v = 16'h0001;
    step(4);
    keys_v = 16'h0000;
    step(4);
    check("bounce_valid", {31'd0, key_valid}, 32'd0);
    check("bounce_col", {28'd0, col_out}, 32'h2);
    check("bounce_down", {31'd0, key_down}, 32'd0);
    step(4);
    check("bounce_scan", {28'd0, col_out}, 32'h4);

    // 4a. Overrun: key 0 left un-acked, then key F
    do_reset();
    keys_v = 16'h0001;
    wait_valid("ovr_first", 100);
    keys_v = 16'h0000;
    wait_release("ovr_release", 100);
    keys_v = 16'h8000;
    ovr_cycles = 0;
    // col1 tick +4, col2 tick +8, capture in col3 at +12, accept at +24
    step(24);
    check("ovr_code", {28'd0, key_code}, 32'hF);
    check("ovr_valid", {31'd0, key_valid}, 32'd1);
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    step(1);
    check("ovr_one_cycle", ovr_cycles, 1);
    ack_v = 1'b1;
    step(1);
    ack_v = 1'b0;
    keys_v = 16'h0000;
    wait_release("ovr_release2", 100);

    // 4b. Ack in the same cycle as the new event
    do_reset();
    keys_v = 16'h0001;
    wait_valid("sim_first", 100);
    keys_v = 16'h0000;
    wait_release("sim_release", 100);
    keys_v = 16'h8000;
    ovr_cycles = 0;
    step(23);
    ack_v = 1'b1;
    step(1);
    ack_v = 1'b0;
    check("sim_valid", {31'd0, key_valid}, 32'd1);
    check("sim_code", {28'd0, key_code}, 32'hF);
    step(1);
    check("sim_no_ovr", ovr_cycles, 0);
    keys_v = 16'h0000;

    // 5. Mid-operation reset: in debounce, then with an event pending
    do_reset();
    keys_v = 16'h0001;
    step(5);
    rst_v = 1'b1;
    step(1);
    rst_v = 1'b0;
    check("mrst_col", {28'd0, col_out}, 32'h1);
    check("mrst_valid", {31'd0, key_valid}, 32'd0);
    check("mrst_down", {31'd0, key_down}, 32'd0);
    wait_valid("mrst_press", 100);
    rst_v = 1'b1;
    step(1);
    rst_v = 1'b0;
    check("mrst2_valid", {31'd0, key_valid}, 32'd0);
    check("mrst2_code", {28'd0, key_code}, 32'h0);
    check("mrst2_col", {28'd0, col_out}, 32'h1);
    check("mrst2_down", {31'd0, key_down}, 32'd0);
    keys_v = 16'h0000;

    // 6. Long hold of key 5 with every event acked
    do_reset();
    keys_v = 16'h0020;
    auto_ack = 1'b1;
    step(90);
    keys_v = 16'h0000;
    wait_release("hold_release", 100);
    auto_ack = 1'b0;
    ack_v = 1'b0;
    check("hold_code", {28'd0, key_code}, 32'h5);
`ifdef KEYPAD_REPEAT_EN
    check("hold_events", val_rises, 4);
`else
    check("hold_events", val_rises, 1);
`endif

    // Random key activity against the reference model
    do_reset();
    for (int it = 0; it < 150; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3) keys_v = 16'h0000;
      else if (sel < 8) keys_v = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 8) keys_v = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      else keys_v = 16'($urandom);
      hold = int'($urandom_range(1, 80));
      for (int c = 0; c < hold; c++) begin
        ack_v = ($urandom_range(0, 3) == 0);
        rst_v = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    rst_v = 1'b0;
    ack_v = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
